// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud divider helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5,
        BREAK  = 3'd6
    } rx_state_e;

    // System clocks per serial bit; shared with the transmitter.
    function automatic int unsigned clock_divide_f(input int unsigned clk_freq,
                                                   input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous inputs, with a configurable reset value.
module uart_sync2 #(
    parameter int unsigned           WIDTH   = 1,
    parameter logic [WIDTH-1:0]      RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 LSB first, mid-bit sampling from a clock-divide counter.
// Define UART_RX_PARITY_EN to receive 8E1 frames and drive parity_err.
module uart_rx #(
    parameter int unsigned clk_freq  = 50000000,
    parameter int unsigned baud_rate = 19200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data_out,
    output logic       rx_active,
    output logic       done_rx,
    output logic       framing_err,
    output logic       parity_err
);

    import uart_pkg::*;

    localparam int unsigned CLOCK_DIVIDE = clock_divide_f(clk_freq, baud_rate);
    localparam int unsigned HALF_DIVIDE  = CLOCK_DIVIDE / 2;
    localparam int unsigned CW           = $clog2(CLOCK_DIVIDE);

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIVIDE - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLOCK_DIVIDE - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    generate
        if (CLOCK_DIVIDE < 4) begin : g_bad_divide
            $error("uart_rx: clk_freq/baud_rate must be at least 4");
        end
    endgenerate

    logic rx_s;

    uart_sync2 #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .rst_n (rst),
        .d     (rx),
        .q     (rx_s)
    );

    rx_state_e   state_q,       state_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic [2:0]  idx_q,         idx_d;
    logic [7:0]  data_q,        data_d;
    logic [7:0]  rx_data_out_q, rx_data_out_d;
    logic        done_q,        done_d;
    logic        ferr_q,        ferr_d;
`ifdef UART_RX_PARITY_EN
    logic        par_bad_q,     par_bad_d;
    logic        perr_q,        perr_d;
`endif

    logic half_hit;
    logic full_hit;

    assign half_hit = (cnt_q == HALF_LAST);
    assign full_hit = (cnt_q == FULL_LAST);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + CNT_ONE;
        idx_d         = idx_q;
        data_d        = data_q;
        rx_data_out_d = rx_data_out_q;
        done_d        = 1'b0;
        ferr_d        = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d     = par_bad_q;
        perr_d        = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end

            START: begin
                if (half_hit) begin
                    cnt_d   = '0;
                    // A high line at mid start bit is a glitch, not a frame.
                    state_d = rx_s ? IDLE : DATA;
                end
            end

            DATA: begin
                if (full_hit) begin
                    cnt_d         = '0;
                    data_d[idx_q] = rx_s;
                    idx_d         = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (full_hit) begin
                    cnt_d     = '0;
                    par_bad_d = (^data_q) ^ rx_s;
                    state_d   = STOP;
                end
            end
`endif

            STOP: begin
                if (full_hit) begin
                    // Outputs are loaded here so they are registered while in DONE.
                    cnt_d         = '0;
                    state_d       = DONE;
                    done_d        = 1'b1;
                    ferr_d        = ~rx_s;
                    rx_data_out_d = data_q;
`ifdef UART_RX_PARITY_EN
                    perr_d        = par_bad_q;
`endif
                end
            end

            DONE: begin
                cnt_d   = '0;
                state_d = ferr_q ? BREAK : IDLE;
            end

            BREAK: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            data_q        <= '0;
            rx_data_out_q <= '0;
            done_q        <= 1'b0;
            ferr_q        <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q     <= 1'b0;
            perr_q        <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            data_q        <= data_d;
            rx_data_out_q <= rx_data_out_d;
            done_q        <= done_d;
            ferr_q        <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q     <= par_bad_d;
            perr_q        <= perr_d;
`endif
        end
    end

    assign rx_data_out = rx_data_out_q;
    assign done_rx     = done_q;
    assign framing_err = ferr_q;
    assign rx_active   = (state_q == START) || (state_q == DATA) ||
                         (state_q == PARITY) || (state_q == STOP);
`ifdef UART_RX_PARITY_EN
    assign parity_err  = perr_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule
